// File: rtl/hist_equ_param.sv
// ============================================================================
// hist_equ_param : per-frame histogram equalisation with double-buffered LUT
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hist_equ_param #(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_de,
    input  logic [DATA_W-1:0] per_img_Y,
    input  logic              bypass,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y,
    output logic              lut_valid,
    output logic              build_busy,
    output logic              drop_err
);

    localparam int NB    = 1 << DATA_W;
    localparam int TOTAL = IMG_HDISP * IMG_VDISP;
    localparam int PW    = CNT_W + DATA_W;
    localparam int SW    = DATA_W + 2;

    typedef enum logic [1:0] {S_INIT = 2'd0, S_COUNT = 2'd1, S_BUILD = 2'd2} state_t;

    state_t            state_q;
    logic [SW-1:0]     cnt_q;
    logic              vs_q, busy_q, lut_valid_q, bank_q, drop_q;
    logic              cv_q, fwd_q;
    logic [DATA_W-1:0] ca_q;
    logic [CNT_W-1:0]  last_q;
    logic              s1_v_q, s2_v_q, s3_v_q;
    logic [DATA_W-1:0] s1_a_q, s2_a_q, s3_a_q, map_q;
    logic [CNT_W-1:0]  cdf_q;
    logic [CNT_W-1:0]  hist_rd_q;
    logic [DATA_W-1:0] lut_rd_q;
    logic              vs1_q, vs2_q, hr1_q, hr2_q, de1_q, de2_q, sel1_q;
    logic [DATA_W-1:0] raw1_q, y_q;

    logic [CNT_W-1:0]  hist_mem [NB];
    logic [DATA_W-1:0] lut_mem  [2*NB];

    logic [CNT_W-1:0]  base_d, inc_d, cdf_d, hwd_d;
    logic [CNT_W:0]    cdf_sum_d;
    logic [PW-1:0]     prod_d, quot_d;
    logic [DATA_W-1:0] map_d, hwa_d, hra_d;
    logic              hwe_d;

    // Back-to-back hits on the same bin: the RAM read misses the write in flight.
    always_comb begin
        base_d    = fwd_q ? last_q : hist_rd_q;
        inc_d     = (&base_d) ? base_d : base_d + 1'b1;
        cdf_sum_d = {1'b0, cdf_q} + {1'b0, hist_rd_q};
        cdf_d     = cdf_sum_d[CNT_W] ? {CNT_W{1'b1}} : cdf_sum_d[CNT_W-1:0];
        prod_d    = PW'(cdf_q) * PW'(NB - 1);
        quot_d    = prod_d / PW'(TOTAL);
        map_d     = (quot_d > PW'(NB - 1)) ? {DATA_W{1'b1}} : quot_d[DATA_W-1:0];
    end

    always_comb begin
        hwe_d = 1'b0;
        hwa_d = ca_q;
        hwd_d = inc_d;
        if (cv_q) begin
            hwe_d = 1'b1;
        end else if (s1_v_q) begin
            hwe_d = 1'b1;
            hwa_d = s1_a_q;
            hwd_d = '0;
        end else if (state_q == S_INIT) begin
            hwe_d = 1'b1;
            hwa_d = cnt_q[DATA_W-1:0];
            hwd_d = '0;
        end
        hra_d = (state_q == S_BUILD) ? cnt_q[DATA_W-1:0] : per_img_Y;
    end

    always_ff @(posedge clk) begin
        if (hwe_d) hist_mem[hwa_d] <= hwd_d;
        hist_rd_q <= hist_mem[hra_d];
        if (s3_v_q) lut_mem[{~bank_q, s3_a_q}] <= map_q;
        lut_rd_q <= lut_mem[{bank_q, per_img_Y}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            vs_q        <= 1'b0;
            busy_q      <= 1'b0;
            lut_valid_q <= 1'b0;
            bank_q      <= 1'b0;
            drop_q      <= 1'b0;
            cv_q        <= 1'b0;
            fwd_q       <= 1'b0;
            ca_q        <= '0;
            last_q      <= '0;
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s2_a_q      <= '0;
            s3_a_q      <= '0;
            map_q       <= '0;
            cdf_q       <= '0;
            vs1_q       <= 1'b0;
            vs2_q       <= 1'b0;
            hr1_q       <= 1'b0;
            hr2_q       <= 1'b0;
            de1_q       <= 1'b0;
            de2_q       <= 1'b0;
            sel1_q      <= 1'b0;
            raw1_q      <= '0;
            y_q         <= '0;
        end else begin
            vs_q   <= per_frame_vsync;
            cv_q   <= per_frame_de && (state_q == S_COUNT);
            ca_q   <= per_img_Y;
            fwd_q  <= per_frame_de && (state_q == S_COUNT) && cv_q && (per_img_Y == ca_q);
            if (cv_q) last_q <= inc_d;
            if (per_frame_de && (state_q != S_COUNT)) drop_q <= 1'b1;

            s1_v_q <= (state_q == S_BUILD) && (cnt_q < SW'(NB));
            s1_a_q <= cnt_q[DATA_W-1:0];
            s2_v_q <= s1_v_q;
            s2_a_q <= s1_a_q;
            s3_v_q <= s2_v_q;
            s3_a_q <= s2_a_q;
            if (s1_v_q) cdf_q <= cdf_d;
            map_q  <= map_d;

            case (state_q)
                S_INIT: begin
                    cnt_q  <= cnt_q + 1'b1;
                    busy_q <= 1'b1;
                    if (cnt_q == SW'(NB - 1)) begin
                        state_q <= S_COUNT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (per_frame_vsync && !vs_q) begin
                        state_q <= S_BUILD;
                        cnt_q   <= '0;
                        cdf_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUILD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SW'(NB + 2)) begin
                        state_q     <= S_COUNT;
                        cnt_q       <= '0;
                        bank_q      <= ~bank_q;
                        lut_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_INIT;
            endcase

            vs1_q  <= per_frame_vsync;
            vs2_q  <= vs1_q;
            hr1_q  <= per_frame_href;
            hr2_q  <= hr1_q;
            de1_q  <= per_frame_de;
            de2_q  <= de1_q;
            raw1_q <= per_img_Y;
            sel1_q <= bypass || !lut_valid_q;
            y_q    <= hr1_q ? (sel1_q ? raw1_q : lut_rd_q) : '0;
        end
    end

    assign post_frame_vsync = vs2_q;
    assign post_frame_href  = hr2_q;
    assign post_frame_clken = de2_q;
    assign post_img_Y       = y_q;
    assign lut_valid        = lut_valid_q;
    assign build_busy       = busy_q;
    assign drop_err         = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_hist_equ_param.sv
// ============================================================================
// tb_hist_equ_param : directed frames through a 16x16 equaliser
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_hist_equ_param;

    localparam int NB = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_de = 1'b0;
    logic [7:0] per_img_Y = '0;
    logic       bypass = 1'b0;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_Y;
    logic       lut_valid, build_busy, drop_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_lut [NB];
    logic       built = 1'b0;
    logic       prev_v = 1'b0;
    logic [7:0] prev_e = '0;

    always #5 clk = ~clk;

    hist_equ_param #(
        .DATA_W   (8),
        .IMG_HDISP(16),
        .IMG_VDISP(16),
        .CNT_W    (20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_de    (per_frame_de),
        .per_img_Y       (per_img_Y),
        .bypass          (bypass),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_Y      (post_img_Y),
        .lut_valid       (lut_valid),
        .build_busy      (build_busy),
        .drop_err        (drop_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, want, $time);
        end
    endtask

    // One clock: apply inputs, then compare the pixel applied one step earlier.
    task automatic step(input logic vs, input logic de, input logic [7:0] y, input logic byp);
        logic [7:0] e;
        per_frame_vsync = vs;
        per_frame_href  = de;
        per_frame_de    = de;
        per_img_Y       = y;
        bypass          = byp;
        e = (byp || !built) ? y : exp_lut[y];
        @(posedge clk);
        #1;
        if (prev_v) begin
            check("pix", post_img_Y, prev_e);
            check("clken", post_frame_clken, 1);
        end
        prev_v = de;
        prev_e = e;
    endtask

    task automatic load_lut(input int mode);
        for (int k = 0; k < NB; k++) begin
            if (mode == 0) exp_lut[k] = 8'(((k + 1) * 255) / 256);
            else           exp_lut[k] = (k < 100) ? 8'd0 : 8'd255;
        end
    endtask

    // mode 0: ramp, 1: all 100, 2: ramp with bypass toggling every 8 pixels
    task automatic send_frame(input int mode);
        for (int i = 0; i < NB; i++) begin
            logic [7:0] y;
            logic       b;
            y = (mode == 1) ? 8'd100 : 8'(i);
            b = (mode == 2) ? i[3] : 1'b0;
            step(1'b0, 1'b1, y, b);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        check("y_zero", post_img_Y, 0);
    endtask

    task automatic do_build(input logic drop, input int lut_mode);
        int n;
        n = 0;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        check("vs_d1", post_frame_vsync, 0);
        check("busy_on", build_busy, 1);
        while (build_busy && n < 1000) begin
            if (drop && n == 100) step(1'b1, 1'b1, 8'd0, 1'b0);
            else                  step(1'b1, 1'b0, 8'd0, 1'b0);
            n++;
            if (n == 1)   check("vs_d2", post_frame_vsync, 1);
            if (n == 200) check("lv_building", lut_valid, built);
        end
        check("build_len", n, 259);
        check("lv_after", lut_valid, 1);
        built = 1'b1;
        load_lut(lut_mode);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wait_init();
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (n < 600 && !(seen && !build_busy)) begin
            step(1'b0, 1'b0, 8'd0, 1'b0);
            if (build_busy) seen = 1'b1;
            n++;
        end
        check("init_len", n, 256);
    endtask

    initial begin
        load_lut(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", post_img_Y, 0);
        check("rst_vs", post_frame_vsync, 0);
        check("rst_href", post_frame_href, 0);
        check("rst_clken", post_frame_clken, 0);
        check("rst_lv", lut_valid, 0);
        check("rst_busy", build_busy, 0);
        check("rst_drop", drop_err, 0);
        rst_n = 1'b1;
        wait_init();

        send_frame(0);
        check("lv_pre", lut_valid, 0);
        do_build(1'b0, 0);
        send_frame(1);
        do_build(1'b0, 1);
        send_frame(2);
        do_build(1'b0, 0);
        send_frame(0);
        check("drop_clr", drop_err, 0);
        do_build(1'b1, 0);
        check("drop_set", drop_err, 1);
        send_frame(0);
        do_build(1'b0, 0);
        send_frame(0);
        check("drop_sticky", drop_err, 1);

        step(1'b1, 1'b0, 8'd0, 1'b0);
        repeat (50) step(1'b1, 1'b0, 8'd0, 1'b0);
        check("mid_busy", build_busy, 1);
        rst_n = 1'b0;
        #2;
        check("mrst_y", post_img_Y, 0);
        check("mrst_vs", post_frame_vsync, 0);
        check("mrst_lv", lut_valid, 0);
        check("mrst_busy", build_busy, 0);
        check("mrst_drop", drop_err, 0);
        built  = 1'b0;
        prev_v = 1'b0;
        repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        wait_init();
        send_frame(0);
        check("lv_post_rst", lut_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hist_equ_param.md
Name: hist_equ_param

Overview:
- Parametrised histogram-equalisation engine for the grey-scale video path. Sits after Y extraction and before display/VGA framing.
- Counts the per-frame histogram with exact back-to-back updates. During vertical blanking it builds a mapping LUT (CDF*(2^DATA_W-1)/TOTAL), then remaps the next frame's pixels through that LUT.
- Compared with the previous block it adds:
  - generic pixel width and image size;
  - inferred internal RAMs;
  - a power-up clear pass;
  - a double-buffered LUT;
  - first-frame and explicit bypass;
  - status flags.

Parameters:
- DATA_W, 8: pixel bits; bins NB = 2^DATA_W.
- IMG_HDISP, 640: active pixels per line.
- IMG_VDISP, 480: active lines per frame; TOTAL = IMG_HDISP*IMG_VDISP, fixed at elaboration.
- CNT_W, 20: bin/CDF counter width; must satisfy 2^CNT_W > TOTAL.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- per_frame_vsync  in  1  high during vertical blanking.
- per_frame_href  in  1  line valid.
- per_frame_de  in  1  pixel valid.
- per_img_Y  in  DATA_W  input pixel.
- bypass  in  1  1 = output raw pixel; histogram counting continues.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_frame_clken  out  1  de delayed 2 cycles.
- post_img_Y  out  DATA_W  equalised or raw pixel; 0 when post_frame_href=0.
- lut_valid  out  1  at least one LUT build completed since reset.
- build_busy  out  1  INIT or BUILD state active.
- drop_err  out  1  sticky: pixel with de=1 arrived while build_busy=1.

Behaviour:
- Reset: all outputs 0; FSM to INIT; LUT bank select 0; sync delay lines 0. RAM contents are undefined after reset and are cleared by INIT.
- FSM states:
  - INIT: write 0 to histogram addresses 0..NB-1, one per cycle; NB cycles, then COUNT.
  - COUNT: histogram updates on de. vsync rising edge (registered compare) -> BUILD.
  - BUILD: NB+3 cycles, then swap LUT bank, set lut_valid=1, go to COUNT.
  - A vsync edge during INIT or BUILD is ignored.
- Histogram update, read-modify-write:
  - Cycle t: read bin Y(t).
  - Cycle t+1: write count+1 to bin Y(t).
  - If Y(t)==Y(t-1), forward the value being written instead of the stale RAM read.
  - Counts must be exact for any pixel sequence, including runs of identical values.
  - Bin increment saturates at 2^CNT_W-1.
- BUILD pipeline, scan k = 0..NB-1:
  - Cycle k: read bin k.
  - Cycle k+1: write 0 to bin k (read-then-clear; no separate clear pass); cdf += count.
  - Cycle k+2: map = (cdf*(2^DATA_W-1))/TOTAL in a CNT_W+DATA_W wide product; saturate to 2^DATA_W-1 (frames longer than TOTAL).
  - Cycle k+3: write map to address k of the inactive LUT bank.
  - cdf resets to 0 at BUILD entry.
- Pixels with de=1 during INIT/BUILD are not counted, set drop_err, and are still output through the active LUT/bypass path.
- Pixel output path:
  - Latency exactly 2 cycles: cycle 0 LUT read from the active bank at per_img_Y, cycle 1 register, cycle 2 output.
  - Output = raw pixel (delayed 2 cycles) if bypass=1 or lut_valid=0; else LUT value.
  - bypass is sampled with the pixel in cycle 0.
- LUT double buffering: the active bank is never written; swap occurs on the cycle after the last LUT write.
- Async reset mid-BUILD: lut_valid returns to 0 and the output falls back to raw pass-through until the next full build.

Test Plan:
- Power-up, DATA_W=8, 16x16 image (TOTAL=256), first frame ramp 0..255 -> post_img_Y equals per_img_Y delayed 2 cycles; lut_valid=0 until first build done; build_busy high NB+3=259 cycles after vsync rise.
- Second frame after ramp-built LUT -> lut[k]=floor((k+1)*255/256): Y=0->0, Y=127->127, Y=255->255.
- Frame of 256 pixels all Y=100, back-to-back de (forwarding) -> bin 100 = 256 exactly; next frame Y=100->255, Y=50->0, Y=200->255.
- Alternate frames all-100 then ramp -> histogram was cleared by build (no carry-over); ramp LUT matches the ramp-LUT scenario exactly.
- bypass=1 with a valid LUT -> raw pixel out; bypass toggled mid-line takes effect on the pixel sampled that cycle; counting unaffected.
- de pulse during BUILD -> drop_err=1 sticky, that pixel uncounted. rst_n low mid-BUILD -> all outputs 0, then INIT 256 cycles, then raw pass-through.
